// File: rtl/led_glow_sched.sv
// LED glow scheduler: a breathing-envelope FSM (up, hold, down, hold) feeding one shared
// PWM engine that drives all LEDs together or chases the glow from LED to LED.
module led_glow_sched #(
  parameter int unsigned NUM_LED    = 4,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 20000,
  parameter int unsigned DUTY_STEP  = 1,
  parameter int unsigned HOLD_TICKS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       mode,
  output logic [NUM_LED-1:0]         led,
  output logic                       busy,
  output logic [$clog2(NUM_LED)-1:0] cur_idx,
  output logic [PWM_BITS-1:0]        duty,
  output logic                       cycle_done
);

  localparam int unsigned IdxW   = $clog2(NUM_LED);
  localparam int unsigned PrescW = $clog2(STEP_DIV);
  localparam int unsigned HoldW  = $clog2(HOLD_TICKS + 1);

  localparam logic [PWM_BITS-1:0] DutyMax   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] Step      = PWM_BITS'(DUTY_STEP);
  localparam logic [PWM_BITS:0]   StepWide  = (PWM_BITS + 1)'(DUTY_STEP);
  localparam logic [PrescW-1:0]   PrescLast = PrescW'(STEP_DIV - 1);
  localparam logic [HoldW-1:0]    HoldLast  = HoldW'(HOLD_TICKS - 1);
  localparam logic [IdxW-1:0]     IdxLast   = IdxW'(NUM_LED - 1);

  typedef enum logic [2:0] {StIdle, StUp, StHoldHi, StDown, StHoldLo} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [IdxW-1:0]     cur_idx_q, cur_idx_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [NUM_LED-1:0]  led_q, led_d;
  logic                cycle_done_q, cycle_done_d;

  logic                tick;
  logic                pwm;
  logic                running;
  logic [PWM_BITS:0]   duty_sum;

  always_comb begin
    running = (state_q != StIdle);
    tick    = running && (presc_q == PrescLast);
    pwm     = (pwm_cnt_q < duty_act_q);
    // One bit wider than duty so the ramp-up clamp never sees a wrapped sum
    duty_sum = {1'b0, duty_q} + StepWide;

    presc_d      = '0;
    pwm_cnt_d    = '0;
    duty_act_d   = '0;
    if (running) begin
      presc_d   = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      // New duty only takes effect at a period boundary to avoid glitches
      duty_act_d = (pwm_cnt_q == DutyMax) ? duty_q : duty_act_q;
    end

    led_d = '0;
    if (running) begin
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        led_d[i] = pwm & (~mode_q | (cur_idx_q == IdxW'(i)));
      end
    end

    state_d      = state_q;
    mode_d       = mode_q;
    cur_idx_d    = cur_idx_q;
    duty_d       = duty_q;
    hold_d       = hold_q;
    cycle_done_d = 1'b0;

    case (state_q)
      StIdle: begin
        duty_d = '0;
        hold_d = '0;
        if (en) begin
          state_d   = StUp;
          mode_d    = mode;
          cur_idx_d = '0;
        end
      end
      StUp: begin
        if (tick) begin
          if (duty_sum >= {1'b0, DutyMax}) begin
            duty_d  = DutyMax;
            hold_d  = '0;
            state_d = StHoldHi;
          end else begin
            duty_d = duty_sum[PWM_BITS-1:0];
          end
        end
      end
      StHoldHi: begin
        if (tick) begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = StDown;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      StDown: begin
        if (tick) begin
          if (duty_q <= Step) begin
            duty_d  = '0;
            hold_d  = '0;
            state_d = StHoldLo;
          end else begin
            duty_d = duty_q - Step;
          end
        end
      end
      StHoldLo: begin
        if (tick) begin
          if (hold_q == HoldLast) begin
            hold_d       = '0;
            cycle_done_d = 1'b1;
            if (!en) begin
              state_d = StIdle;
            end else begin
              state_d = StUp;
              mode_d  = mode;
              // Chase continues to the next LED; a fresh chase or all-mode starts at LED 0
              if (mode && mode_q) begin
                cur_idx_d = (cur_idx_q == IdxLast) ? '0 : cur_idx_q + 1'b1;
              end else begin
                cur_idx_d = '0;
              end
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      cur_idx_q    <= '0;
      duty_q       <= '0;
      duty_act_q   <= '0;
      pwm_cnt_q    <= '0;
      presc_q      <= '0;
      hold_q       <= '0;
      led_q        <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cur_idx_q    <= cur_idx_d;
      duty_q       <= duty_d;
      duty_act_q   <= duty_act_d;
      pwm_cnt_q    <= pwm_cnt_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      led_q        <= led_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign led        = led_q;
  assign busy       = (state_q != StIdle);
  assign cur_idx    = cur_idx_q;
  assign duty       = duty_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_glow_sched.sv
// Bench for led_glow_sched: randomized stimulus compared clock by clock against a model that
// derives duty, PWM and LED ownership from elapsed time since the run started.
module tb_led_glow_sched;

  localparam int NL   = 4;
  localparam int PB   = 4;
  localparam int SD   = 4;
  localparam int ST   = 5;
  localparam int ST2  = 7;
  localparam int HT   = 2;
  localparam int MAXD = 15;
  localparam int PER  = 16;

  logic       clk;
  logic       rst_n;
  logic       en, mode, en2, mode2;
  logic [3:0] led, led2;
  logic       busy, busy2;
  logic [1:0] cur_idx, idx2;
  logic [3:0] duty, duty2;
  logic       cycle_done, done2;

  int checks = 0;
  int errors = 0;

  led_glow_sched #(
    .NUM_LED(NL), .PWM_BITS(PB), .STEP_DIV(SD), .DUTY_STEP(ST), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .led(led), .busy(busy),
    .cur_idx(cur_idx), .duty(duty), .cycle_done(cycle_done)
  );

  led_glow_sched #(
    .NUM_LED(NL), .PWM_BITS(PB), .STEP_DIV(SD), .DUTY_STEP(ST2), .HOLD_TICKS(HT)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .led(led2), .busy(busy2),
    .cur_idx(idx2), .duty(duty2), .cycle_done(done2)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  // ---- reference model: everything is a function of t = clocks since the run started ----
  bit         m_run;
  int         m_t;
  bit         m_mode;
  int         m_idx;
  bit         m_done;
  logic [3:0] m_led;

  function automatic int up_len(int step);
    return (MAXD + step - 1) / step;
  endfunction

  function automatic int cyc_ticks(int step);
    return 2 * up_len(step) + 2 * HT;
  endfunction

  // Duty right after the k-th tick (1-based) of one envelope cycle
  function automatic int env_at(int step, int k);
    int j;
    if (k <= up_len(step)) return (k * step > MAXD) ? MAXD : k * step;
    if (k <= up_len(step) + HT) return MAXD;
    if (k <= 2 * up_len(step) + HT) begin
      j = k - up_len(step) - HT;
      return (MAXD - j * step < 0) ? 0 : MAXD - j * step;
    end
    return 0;
  endfunction

  function automatic int duty_of(int t);
    int k;
    k = t / SD;
    if (k == 0) return 0;
    return env_at(ST, ((k - 1) % cyc_ticks(ST)) + 1);
  endfunction

  function automatic int act_of(int t);
    int p;
    p = t / PER;
    if (p == 0) return 0;
    return duty_of(p * PER - 1);
  endfunction

  function automatic bit pwm_of(int t);
    return (t % PER) < act_of(t);
  endfunction

  function automatic logic [3:0] exp_duty();
    return m_run ? 4'(duty_of(m_t)) : 4'd0;
  endfunction

  task automatic model_clear();
    m_run = 1'b0; m_t = 0; m_mode = 1'b0; m_idx = 0; m_done = 1'b0; m_led = '0;
  endtask

  // Advance one clock: DUT samples en/mode at the edge; model follows the same edge.
  task automatic tick_clk();
    logic       en_s, mode_s;
    logic [3:0] nl;
    en_s = en;
    mode_s = mode;
    nl = '0;
    if (m_run) begin
      if (m_mode) nl[m_idx] = pwm_of(m_t);
      else nl = {4{pwm_of(m_t)}};
    end
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (!m_run) begin
      if (en_s) begin
        m_run = 1'b1; m_t = 0; m_mode = mode_s; m_idx = 0;
      end
    end else begin
      m_t++;
      if ((m_t % SD == 0) && ((m_t / SD) % cyc_ticks(ST) == 0)) begin
        m_done = 1'b1;
        if (!en_s) m_run = 1'b0;
        else begin
          m_idx = (mode_s && m_mode) ? (m_idx + 1) % NL : 0;
          m_mode = mode_s;
        end
      end
    end
    m_led = nl;
  endtask

  task automatic drain();
    int n;
    n = 0;
    en = 1'b0;
    while (m_run && n < 200) begin
      tick_clk();
      n++;
    end
    tick_clk();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: busy=%0b expected 0", busy);
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; en2 = 1'b0; mode2 = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (led !== 4'd0) begin errors++; $display("FAIL reset_led: got %0h expected 0", led); end
    if (duty !== 4'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (cur_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", cur_idx); end
    if (cycle_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %0b expected 0", cycle_done);
    end
    #10 rst_n = 1'b1;
    en = 1'b1;
    repeat (15) tick_clk();
    checks++;
    if (duty !== exp_duty() || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_run: duty=%0d busy=%0b expected %0d 1", duty, busy,
                         exp_duty());
    end
    #11 rst_n = 1'b0;
    #1;
    checks += 3;
    if (led !== 4'd0) begin errors++; $display("FAIL async_rst_led: got %0h expected 0", led); end
    if (duty !== 4'd0) begin errors++; $display("FAIL async_rst_duty: got %0d expected 0", duty); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %0b expected 0", busy); end
    en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      checks++;
      if (busy !== 1'b0 || led !== 4'd0) begin
        errors++; $display("FAIL idle_after_rst: busy=%0b led=%0h expected 0 0", busy, led);
      end
    end
    en = 1'b1;
    tick_clk();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_on_en: busy=%0b expected 1", busy); end
    drain();
  endtask

  task automatic test_envelope();
    int tbl[10] = '{5, 10, 15, 15, 15, 10, 5, 0, 0, 0};
    mode = 1'b0;
    en = 1'b0;
    repeat ($urandom_range(0, 3)) tick_clk();
    en = 1'b1;
    tick_clk();
    for (int n = 1; n <= 80; n++) begin
      tick_clk();
      checks += 4;
      if (duty !== exp_duty()) begin
        errors++; $display("FAIL env_duty t=%0d: got %0d expected %0d", n, duty, exp_duty());
      end
      if (led !== m_led || (led !== 4'h0 && led !== 4'hf)) begin
        errors++; $display("FAIL env_led t=%0d: got %0h expected %0h", n, led, m_led);
      end
      if (busy !== m_run) begin
        errors++; $display("FAIL env_busy t=%0d: got %0b expected %0b", n, busy, m_run);
      end
      if (cycle_done !== m_done) begin
        errors++; $display("FAIL env_done t=%0d: got %0b expected %0b", n, cycle_done, m_done);
      end
      if (n <= 40 && n % SD == 0) begin
        checks++;
        if (duty !== 4'(tbl[n / SD - 1])) begin
          errors++; $display("FAIL env_tick%0d: got %0d expected %0d", n / SD, duty, tbl[n / SD - 1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_pwm_ratio();
    int cnt[4];
    mode = 1'b0;
    en = 1'b1;
    tick_clk();
    repeat (PER) tick_clk();
    for (int p = 1; p <= 9; p++) begin
      for (int b = 0; b < 4; b++) cnt[b] = 0;
      for (int j = 0; j < PER; j++) begin
        tick_clk();
        for (int b = 0; b < 4; b++) cnt[b] += int'(led[b]);
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (cnt[b] != duty_of(p * PER - 1)) begin
          errors++; $display("FAIL pwm_ratio p=%0d led%0d: high %0d of 16 expected %0d", p, b,
                             cnt[b], duty_of(p * PER - 1));
        end
      end
    end
    drain();
  endtask

  task automatic test_chase();
    int tbl[4] = '{1, 2, 3, 0};
    int nd;
    logic [3:0] others;
    nd = 0;
    mode = 1'b1;
    en = 1'b1;
    tick_clk();
    checks++;
    if (cur_idx !== 2'd0) begin errors++; $display("FAIL chase_start_idx: got %0d expected 0", cur_idx); end
    for (int n = 1; n <= 160; n++) begin
      tick_clk();
      others = led & ~(4'b0001 << cur_idx);
      checks += 3;
      if (cur_idx !== 2'(m_idx)) begin
        errors++; $display("FAIL chase_idx t=%0d: got %0d expected %0d", n, cur_idx, m_idx);
      end
      if (led !== m_led) begin
        errors++; $display("FAIL chase_led t=%0d: got %0h expected %0h", n, led, m_led);
      end
      if (others !== 4'd0) begin
        errors++; $display("FAIL chase_others t=%0d: got %0h expected 0", n, others);
      end
      if (cycle_done === 1'b1 && nd < 4) begin
        checks++;
        if (cur_idx !== 2'(tbl[nd])) begin
          errors++; $display("FAIL chase_seq%0d: got %0d expected %0d", nd, cur_idx, tbl[nd]);
        end
        nd++;
      end
    end
    checks++;
    if (nd != 4) begin errors++; $display("FAIL chase_cycles: got %0d expected 4", nd); end
    mode = 1'b0;
    drain();
  endtask

  task automatic test_graceful_stop();
    int drop_at, done_t;
    done_t = -1;
    drop_at = $urandom_range(0, 11);
    mode = 1'($urandom_range(0, 1));
    en = 1'b1;
    tick_clk();
    for (int n = 1; n <= 60; n++) begin
      if (n > drop_at) en = 1'b0;
      tick_clk();
      checks += 3;
      if (busy !== m_run) begin
        errors++; $display("FAIL stop_busy t=%0d: got %0b expected %0b", n, busy, m_run);
      end
      if (led !== m_led) begin
        errors++; $display("FAIL stop_led t=%0d: got %0h expected %0h", n, led, m_led);
      end
      if (cycle_done !== m_done) begin
        errors++; $display("FAIL stop_done t=%0d: got %0b expected %0b", n, cycle_done, m_done);
      end
      if (cycle_done === 1'b1) done_t = n;
    end
    checks += 2;
    if (done_t != cyc_ticks(ST) * SD) begin
      errors++; $display("FAIL stop_cycle_len: got %0d expected %0d", done_t, cyc_ticks(ST) * SD);
    end
    if (busy !== 1'b0 || led !== 4'd0) begin
      errors++; $display("FAIL stop_final: busy=%0b led=%0h expected 0 0", busy, led);
    end
    drain();
  endtask

  task automatic test_saturation();
    int tbl7[10] = '{7, 14, 15, 15, 15, 8, 1, 0, 0, 0};
    en2 = 1'b1;
    mode2 = 1'b0;
    tick_clk();
    en2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      repeat (SD) tick_clk();
      checks++;
      if (duty2 !== 4'(tbl7[k - 1])) begin
        errors++; $display("FAIL sat_tick%0d: got %0d expected %0d", k, duty2, tbl7[k - 1]);
      end
    end
    checks++;
    if (done2 !== 1'b1) begin errors++; $display("FAIL sat_done: got %0b expected 1", done2); end
    tick_clk();
    checks++;
    if (busy2 !== 1'b0 || led2 !== 4'd0) begin
      errors++; $display("FAIL sat_stop: busy=%0b led=%0h expected 0 0", busy2, led2);
    end
  endtask

  task automatic test_mode_change();
    int seen_all;
    seen_all = 0;
    mode = 1'b1;
    en = 1'b1;
    tick_clk();
    for (int n = 1; n <= 160; n++) begin
      if (n == 94) mode = 1'b0;
      tick_clk();
      checks += 2;
      if (led !== m_led) begin
        errors++; $display("FAIL mc_led t=%0d: got %0h expected %0h", n, led, m_led);
      end
      if (cur_idx !== 2'(m_idx)) begin
        errors++; $display("FAIL mc_idx t=%0d: got %0d expected %0d", n, cur_idx, m_idx);
      end
      if (n > 80 && n <= 120) begin
        checks++;
        if ((led & 4'b1011) !== 4'd0) begin
          errors++; $display("FAIL mc_single t=%0d: got %0h expected only bit2", n, led);
        end
      end
      if (n > 121) begin
        checks++;
        if (led !== 4'h0 && led !== 4'hf) begin
          errors++; $display("FAIL mc_all t=%0d: got %0h expected 0 or f", n, led);
        end
        if (led === 4'hf) seen_all++;
      end
      if (n == 121) begin
        checks++;
        if (cur_idx !== 2'd0) begin errors++; $display("FAIL mc_idx0: got %0d expected 0", cur_idx); end
      end
    end
    checks++;
    if (seen_all == 0) begin errors++; $display("FAIL mc_glow: got 0 all-on clocks expected >0"); end
    drain();
  endtask

  task automatic test_random();
    en = 1'b0;
    mode = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      tick_clk();
      checks += 5;
      if (led !== m_led) begin
        errors++; $display("FAIL rnd_led n=%0d: got %0h expected %0h", n, led, m_led);
      end
      if (duty !== exp_duty()) begin
        errors++; $display("FAIL rnd_duty n=%0d: got %0d expected %0d", n, duty, exp_duty());
      end
      if (busy !== m_run) begin
        errors++; $display("FAIL rnd_busy n=%0d: got %0b expected %0b", n, busy, m_run);
      end
      if (cur_idx !== 2'(m_idx)) begin
        errors++; $display("FAIL rnd_idx n=%0d: got %0d expected %0d", n, cur_idx, m_idx);
      end
      if (cycle_done !== m_done) begin
        errors++; $display("FAIL rnd_done n=%0d: got %0b expected %0b", n, cycle_done, m_done);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_envelope();
    test_pwm_ratio();
    test_chase();
    test_graceful_stop();
    test_saturation();
    test_mode_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
